// File: rtl/cb_pkg.sv
// Shared crossbar types: active-low request/response encodings, source FSM
// states and the buffer depth derivation used by sources and the crossbar.
package cb_pkg;

  typedef enum logic {
    REQ  = 1'b0,
    nREQ = 1'b1
  } req_t;

  typedef enum logic {
    RESP  = 1'b0,
    nRESP = 1'b1
  } resp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_WAIT = 2'd1,
    REL_WAIT = 2'd2
  } fsm_t;

  // Number of buffer words for a given log2 depth.
  function automatic int buff_depth(input int bwidth);
    return 32'sd1 << bwidth;
  endfunction

endpackage

// File: rtl/cb_src_if.sv
// Local push side and crossbar request/response side of a crossbar source.
// master: the cb_src view; slave: the environment driving it.
interface cb_src_if #(
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 3
);
  import cb_pkg::*;

  logic [DWIDTH-1:0] push_data;
  logic              push_valid;
  logic              push_ready;
  logic [DWIDTH-1:0] data;
  req_t              Ireq;
  resp_t             Oresp;
  logic [BWIDTH:0]   level;
  logic              tmo_err;
  logic              tmo_clr;

  modport master (
    input  push_data, push_valid, Oresp, tmo_clr,
    output push_ready, data, Ireq, level, tmo_err
  );

  modport slave (
    output push_data, push_valid, Oresp, tmo_clr,
    input  push_ready, data, Ireq, level, tmo_err
  );

endinterface

// File: rtl/cb_fifo.sv
// Word buffer for a crossbar source. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module cb_fifo
  import cb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [BWIDTH:0]   level
);

  localparam int              DEPTH   = buff_depth(BWIDTH);
  localparam logic [BWIDTH:0] PTR_ONE = {{BWIDTH{1'b0}}, 1'b1};

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [BWIDTH:0]   wr_ptr_r;
  logic [BWIDTH:0]   rd_ptr_r;
  logic              do_push_s;
  logic              do_pop_s;

  // A push while full is dropped even if a pop happens on the same edge.
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[BWIDTH] != rd_ptr_r[BWIDTH]) &&
                   (wr_ptr_r[BWIDTH-1:0] == rd_ptr_r[BWIDTH-1:0]);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign rd_data = mem[rd_ptr_r[BWIDTH-1:0]];

  // Pointer update; reset empties the buffer without touching storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {(BWIDTH+1){1'b0}};
      rd_ptr_r <= {(BWIDTH+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push_s) mem[wr_ptr_r[BWIDTH-1:0]] <= push_data;
  end

endmodule

// File: rtl/cb_src.sv
// Crossbar source: buffers local words and offers them one at a time to the
// crossbar with a four-phase REQ/RESP handshake, flagging slow responses.
module cb_src
  import cb_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 3,
  parameter int TMO    = 255
) (
  input logic       clk,
  input logic       rstn,
  cb_src_if.master  bus
);

  localparam int          CW      = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_C   = CW'(TMO);
  localparam logic [CW-1:0] TMO_M1  = CW'(TMO - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  fsm_t              state_r, state_s;
  logic [DWIDTH-1:0] data_r, data_s;
  req_t              ireq_r, ireq_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              tmo_err_r, tmo_err_s;
  logic              set_s;
  logic              pop_s;
  logic [DWIDTH-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BWIDTH:0]   fifo_level;

  cb_fifo #(
    .DWIDTH (DWIDTH),
    .BWIDTH (BWIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (bus.push_valid),
    .push_data (bus.push_data),
    .pop       (pop_s),
    .rd_data   (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.push_ready = ~fifo_full;
  assign bus.level      = fifo_level;
  assign bus.data       = data_r;
  assign bus.Ireq       = ireq_r;
  assign bus.tmo_err    = tmo_err_r;

  // Handshake sequencing, pop request and REQ_WAIT cycle counting.
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    ireq_s  = ireq_r;
    pop_s   = 1'b0;
    cnt_s   = {CW{1'b0}};
    set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // RESP seen here is ignored: nothing is outstanding.
        if (!fifo_empty) begin
          state_s = REQ_WAIT;
          data_s  = fifo_data;
          ireq_s  = REQ;
        end else begin
          ireq_s  = nREQ;
        end
      end
      REQ_WAIT: begin
        // Counter saturates; only the step onto TMO raises the flag.
        if (cnt_r != TMO_C) cnt_s = cnt_r + CNT_ONE;
        else                cnt_s = cnt_r;
        if (cnt_r == TMO_M1) set_s = 1'b1;
        else                 set_s = 1'b0;
        if (bus.Oresp == RESP) begin
          ireq_s  = nREQ;
          pop_s   = 1'b1;
          cnt_s   = {CW{1'b0}};
          state_s = REL_WAIT;
        end else begin
          ireq_s  = REQ;
        end
      end
      REL_WAIT: begin
        ireq_s = nREQ;
        if (bus.Oresp == nRESP) state_s = IDLE;
        else                    state_s = REL_WAIT;
      end
      default: begin
        state_s = IDLE;
        ireq_s  = nREQ;
      end
    endcase
  end

  // Sticky timeout flag; a set on the same edge as a clear wins.
  always_comb begin
    if (set_s)             tmo_err_s = 1'b1;
    else if (bus.tmo_clr)  tmo_err_s = 1'b0;
    else                   tmo_err_s = tmo_err_r;
  end

  // State and registered outputs; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      data_r    <= {DWIDTH{1'b0}};
      ireq_r    <= nREQ;
      cnt_r     <= {CW{1'b0}};
      tmo_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      data_r    <= data_s;
      ireq_r    <= ireq_s;
      cnt_r     <= cnt_s;
      tmo_err_r <= tmo_err_s;
    end
  end

endmodule
